// File: rtl/ctl_pic_pkg.sv
// rtl/ctl_pic_pkg.sv - shared register offsets and bit positions for ctl_pic
package ctl_pic_pkg;
  localparam int MAX_IRQ = 16;

  localparam logic [1:0] OFS_CMD    = 2'd0;
  localparam logic [1:0] OFS_IMR_LO = 2'd1;
  localparam logic [1:0] OFS_IRR    = 2'd2;
  localparam logic [1:0] OFS_IMR_HI = 2'd3;

  localparam int EOI_BIT  = 5;
  localparam int SPEC_BIT = 6;
endpackage

// File: rtl/pic_prio_enc.sv
// rtl/pic_prio_enc.sv - lowest-set-bit priority encoder
module pic_prio_enc #(
  parameter int WIDTH = 8,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/ctl_pic.sv
// rtl/ctl_pic.sv - edge-triggered nested-priority interrupt controller on the CPU port bus
module ctl_pic
  import ctl_pic_pkg::*;
#(
  parameter int              NUM_IRQ     = 8,
  parameter logic [7:0]      VECTOR_BASE = 8'h08,
  parameter logic [15:0]     PORT_BASE   = 16'h0020,
  parameter logic [NUM_IRQ-1:0] IMR_RESET = '1
) (
  input  logic               clock_cpu,
  input  logic               reset_n,
  input  logic [15:0]        port_address,
  input  logic [7:0]         port_out,
  input  logic               port_write,
  input  logic               port_read,
  output logic [7:0]         port_in,
  output logic               port_ready,
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic               irq_signal,
  output logic [7:0]         irq
);
  localparam int IDX_W = $clog2(NUM_IRQ);
  localparam int LO_W  = (NUM_IRQ < 8) ? NUM_IRQ : 8;
  localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);

  logic [NUM_IRQ-1:0] irr, isr, imr, req_prev;
  logic [NUM_IRQ-1:0] edge_set, deliver_set, eoi_clr, imr_nxt;
  logic [15:0]        ofs, imr16;
  logic [7:0]         irr_lo, isr_lo, rd_data;
  logic [1:0]         sel;
  logic               hit, cand_v, isr_v, deliver, cmd_wr;
  logic [IDX_W-1:0]   cand_idx, isr_idx;

  assign port_ready = 1'b1;
  assign ofs        = port_address - PORT_BASE;
  assign hit        = (ofs[15:2] == 14'd0);
  assign sel        = ofs[1:0];
  assign edge_set   = irq_req & ~req_prev;

  pic_prio_enc #(.WIDTH(NUM_IRQ)) u_cand (
    .req   (irr & ~imr),
    .valid (cand_v),
    .idx   (cand_idx)
  );

  // Lowest in-service line: drives both the nesting block and non-specific EOI.
  pic_prio_enc #(.WIDTH(NUM_IRQ)) u_isr (
    .req   (isr),
    .valid (isr_v),
    .idx   (isr_idx)
  );

  assign deliver     = cand_v && !(isr_v && (isr_idx <= cand_idx));
  assign deliver_set = deliver ? (ONE << cand_idx) : '0;
  assign cmd_wr      = port_write && hit && (sel == OFS_CMD) && port_out[EOI_BIT];

  always_comb begin
    eoi_clr = '0;
    if (cmd_wr) begin
      if (port_out[SPEC_BIT]) begin
        if (int'(port_out[3:0]) < NUM_IRQ) eoi_clr = ONE << port_out[3:0];
      end else if (isr_v) begin
        eoi_clr = ONE << isr_idx;
      end
    end
  end

  // Unimplemented bits of the 16-bit mask view stay 1 and are never writable.
  always_comb begin
    imr16               = '1;
    imr16[NUM_IRQ-1:0]  = imr;
    irr_lo              = '1;
    irr_lo[LO_W-1:0]    = irr[LO_W-1:0];
    isr_lo              = '1;
    isr_lo[LO_W-1:0]    = isr[LO_W-1:0];
    imr_nxt             = imr;
    if (port_write && hit && sel == OFS_IMR_LO) begin
      imr_nxt = imr16[NUM_IRQ-1:0];
      for (int i = 0; i < LO_W; i++) imr_nxt[i] = port_out[i];
    end
    if (port_write && hit && sel == OFS_IMR_HI && NUM_IRQ > 8) begin
      imr_nxt = imr16[NUM_IRQ-1:0];
      for (int i = 8; i < NUM_IRQ; i++) imr_nxt[i] = port_out[i-8];
    end
  end

  always_comb begin
    rd_data = 8'hFF;
    if (hit) begin
      case (sel)
        OFS_CMD:    rd_data = isr_lo;
        OFS_IMR_LO: rd_data = imr16[7:0];
        OFS_IRR:    rd_data = irr_lo;
        default:    rd_data = imr16[15:8];
      endcase
    end
  end

  always_ff @(posedge clock_cpu) begin
    if (!reset_n) begin
      irr        <= '0;
      isr        <= '0;
      imr        <= IMR_RESET;
      req_prev   <= '1;
      irq_signal <= 1'b0;
      irq        <= 8'h00;
      port_in    <= 8'hFF;
    end else begin
      req_prev <= irq_req;
      irr      <= (irr & ~deliver_set) | edge_set;
      isr      <= (isr & ~eoi_clr) | deliver_set;
      imr      <= imr_nxt;
      if (deliver) begin
        irq_signal <= ~irq_signal;
        irq        <= VECTOR_BASE + 8'(cand_idx);
      end
      if (port_read) port_in <= rd_data;
    end
  end
endmodule

// File: doc/ctl_pic.md
# ctl_pic

Parametrised programmable interrupt controller for the CPU port bus. It generalises the single fixed keyboard IRQ path to NUM_IRQ edge-triggered request lines and adds a software-writable mask, an in-service register with fully nested priority, and non-specific and specific EOI. It sits beside the port controller on the same port_address/port_in/port_out strobes and drives the CPU's toggle-style interrupt request.

## Interface
Parameters:
- NUM_IRQ, 8: number of request lines, legal range 2..16; line 0 has the highest priority.
- VECTOR_BASE, 8'h08: vector number delivered for line 0.
- PORT_BASE, 16'h0020: base port address; the block decodes PORT_BASE+0..+3.
- IMR_RESET, all ones: mask value loaded at reset.

Ports:
- clock_cpu  in  1  sole clock.
- reset_n  in  1  synchronous reset, active low.
- port_address  in  16  port address.
- port_out  in  8  write data from the CPU.
- port_write  in  1  one-cycle write strobe.
- port_read  in  1  one-cycle read strobe.
- port_in  out  8  read data (registered).
- port_ready  out  1  constant 1.
- irq_req  in  NUM_IRQ  request lines, already synchronous to clock_cpu; rising edge = request.
- irq_signal  out  1  toggles once per delivered interrupt.
- irq  out  8  vector of the last delivered interrupt.

## Operation
Reset (reset_n=0 at an edge):
- IRR=0, ISR=0, IMR=IMR_RESET, req_prev=all ones.
- irq_signal=0, irq=0, port_in=8'hFF, port_ready=1.

Request capture:
- A rising edge is irq_req[i]=1 while req_prev[i]=0. It sets IRR[i].
- An edge on a line whose IRR bit is already set is coalesced.
- If an edge on line i coincides with the delivery of line i, IRR[i] stays 1.

Delivery:
- Candidate = lowest i with IRR[i]=1 and IMR[i]=0.
- The candidate is delivered only if no ISR[j]=1 for any j<=i (fully nested).
- On delivery: IRR[i] is cleared, ISR[i] is set, irq becomes VECTOR_BASE+i, and irq_signal toggles.
- At most one delivery per cycle.
- The decision uses registered IRR, IMR and ISR from before this cycle's port writes.

Register map (offsets from PORT_BASE):
- +0 write: bit5=1 with bit6=0 is a non-specific EOI; it clears the lowest-index set ISR bit. bit5=1 with bit6=1 is a specific EOI; it clears ISR[port_out[3:0]], and is ignored if the index is >= NUM_IRQ. bit5=0 has no effect.
- +0 read: ISR[7:0].
- +1 read/write: IMR[7:0].
- +2 read: IRR[7:0].
- +3 read/write: IMR[15:8]. Only implemented when NUM_IRQ>8; otherwise writes are ignored and reads return 8'hFF.
- Unimplemented bits read as 1; other addresses read 8'hFF.
- port_in updates only on port_read.

Simultaneous events:
- Delivery and EOI in the same cycle both apply: ISR = (ISR & ~eoi_clear) | deliver_set.
- A mask write takes effect for delivery from the next cycle.
- Reset mid-operation discards all pending and in-service state.

## Timing
- irq_req[i] goes high before edge k, so IRR[i] is set after edge k. Delivery happens at edge k+1, so irq_signal toggles 2 cycles after the input rises, if the line is unmasked and not blocked.
- A pending, previously blocked request is delivered on the edge after the EOI that unblocks it, i.e. 1 cycle after the EOI write.
- Reads: port_in is valid the cycle after the port_read edge.

## Structure
- Package ctl_pic_pkg holds:
  - register offsets OFS_CMD=0, OFS_IMR_LO=1, OFS_IRR=2, OFS_IMR_HI=3;
  - EOI bit positions (EOI_BIT=5, SPEC_BIT=6);
  - the 16-bit width constant MAX_IRQ=16.
- Sub-module pic_prio_enc: parametrised WIDTH, outputs valid and lowest set index. It is instantiated for the delivery candidate, the ISR nesting check and the non-specific EOI.

## Test plan
- Reset, IMR=FF, pulse irq_req[1]: no toggle. Write 8'hFD to +1, then irq_signal toggles 1 cycle later, irq=8'h09, reading +0 returns 8'h02.
- IMR=00, raise lines 3 and 5 in the same cycle: toggle with irq=8'h0B. Line 5 stays pending with IRR read 8'h20. Write 8'h20 to +0, then line 5 delivers next cycle with irq=8'h0D.
- While ISR[4]=1, raise line 2: nested delivery with irq=8'h0A and ISR=8'h14. Non-specific EOI clears bit 2, leaving ISR=8'h10.
- Specific EOI 8'h64 clears ISR[4] only. 8'h6F with NUM_IRQ=8 changes nothing.
- NUM_IRQ=16, VECTOR_BASE=8'h70: write 8'hFE to +3, raise line 8. Result is irq=8'h78; reading +3 returns 8'hFE. Assert reset_n mid-pending, after which IRR=ISR=0 and there is no toggle.
